// File: rtl/reset_release_sequencer.sv
// Reset release sequencer: async assertion, synchronized and stretched deassertion, ordered
// per-domain release, and a software warm-reset request/acknowledge handshake.
module reset_release_sequencer #(
    parameter int unsigned SYNC_STAGES = 3,
    parameter int unsigned STRETCH     = 16,
    parameter int unsigned N_DOMAINS   = 4,
    parameter int unsigned GAP         = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sw_req,
    output logic                 sw_ack,
    output logic [N_DOMAINS-1:0] dom_rst,
    output logic                 done
);

    localparam int unsigned CNT_MAX = (STRETCH > GAP) ? STRETCH : GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int unsigned IDX_W   = $clog2(N_DOMAINS) + 1;

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(N_DOMAINS - 1);

    localparam logic [2:0] ST_HOLD    = 3'd0;
    localparam logic [2:0] ST_STRETCH = 3'd1;
    localparam logic [2:0] ST_RELEASE = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_SWRST   = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_ok;
    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [N_DOMAINS-1:0]   dom_q, dom_d;
    logic                   done_q, done_d;
    logic                   ack_q, ack_d;

    // Deassertion synchronizer: cleared only by rst_n, never synchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_ok = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        done_d  = done_q;
        ack_d   = ack_q;
        case (state_q)
            ST_HOLD: begin
                if (sync_ok) begin
                    state_d = ST_STRETCH;
                    cnt_d   = '0;
                end
            end
            ST_STRETCH: begin
                if (cnt_q == STRETCH_LAST) begin
                    cnt_d    = '0;
                    idx_d    = '0;
                    dom_d[0] = 1'b0;
                    if (N_DOMAINS == 1) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d        = '0;
                    idx_d        = idx_q + IDX_W'(1);
                    dom_d[idx_d] = 1'b0;
                    if (idx_d == IDX_LAST) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (sw_req) begin
                    state_d = ST_SWRST;
                    dom_d   = '1;
                    done_d  = 1'b0;
                    ack_d   = 1'b1;
                end
            end
            ST_SWRST: begin
                // Warm reset restarts at the stretch; the synchronizer stays settled.
                if (!sw_req) begin
                    state_d = ST_STRETCH;
                    cnt_d   = '0;
                    ack_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '1;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
        end
    end

    assign dom_rst = dom_q;
    assign done    = done_q;
    assign sw_ack  = ack_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Directed bench for reset_release_sequencer: default instance plus a minimum-parameter instance.
module tb_reset_release_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sw_req;
    logic       sw_ack;
    logic [3:0] dom_rst;
    logic       done;

    logic       rst_n2;
    logic       sw_ack2;
    logic [0:0] dom_rst2;
    logic       done2;

    int checks   = 0;
    int failures = 0;
    int cur_edge = -1;

    typedef struct {
        int         e;
        logic       req;
        logic [3:0] dom;
        logic       dn;
        logic       ack;
    } vec_t;

    vec_t seq_a[$];
    vec_t seq_b[$];

    reset_release_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_req  (sw_req),
        .sw_ack  (sw_ack),
        .dom_rst (dom_rst),
        .done    (done)
    );

    reset_release_sequencer #(
        .SYNC_STAGES (2),
        .STRETCH     (1),
        .N_DOMAINS   (1),
        .GAP         (1)
    ) dut_min (
        .clk     (clk),
        .rst_n   (rst_n2),
        .sw_req  (1'b0),
        .sw_ack  (sw_ack2),
        .dom_rst (dom_rst2),
        .done    (done2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%0h required=%0h", name, cur_edge, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cur_edge++;
    endtask

    task automatic run_vecs(input vec_t v[$]);
        foreach (v[i]) begin
            sw_req = v[i].req;
            while (cur_edge < v[i].e) step();
            check("dom_rst", 32'(dom_rst), 32'(v[i].dom));
            check("done", 32'(done), 32'(v[i].dn));
            check("sw_ack", 32'(sw_ack), 32'(v[i].ack));
        end
    endtask

    // Invariants sampled away from the active edge.
    always @(negedge clk) begin
        logic [3:0] inv;
        inv = ~dom_rst;
        check("thermometer", 32'((inv & (inv + 4'd1)) == 4'd0), 32'd1);
        check("done_iff_released", 32'(done), 32'(dom_rst == 4'd0));
        check("min_done_iff_released", 32'(done2), 32'(dom_rst2 == 1'b0));
    end

    initial begin
        // Power-on release, then warm reset at edges 40/45.
        seq_a.push_back('{0,  1'b0, 4'b1111, 1'b0, 1'b0});
        seq_a.push_back('{2,  1'b0, 4'b1111, 1'b0, 1'b0});
        seq_a.push_back('{18, 1'b0, 4'b1111, 1'b0, 1'b0});
        seq_a.push_back('{19, 1'b0, 4'b1110, 1'b0, 1'b0});
        seq_a.push_back('{22, 1'b0, 4'b1110, 1'b0, 1'b0});
        seq_a.push_back('{23, 1'b0, 4'b1100, 1'b0, 1'b0});
        seq_a.push_back('{26, 1'b0, 4'b1100, 1'b0, 1'b0});
        seq_a.push_back('{27, 1'b0, 4'b1000, 1'b0, 1'b0});
        seq_a.push_back('{30, 1'b0, 4'b1000, 1'b0, 1'b0});
        seq_a.push_back('{31, 1'b0, 4'b0000, 1'b1, 1'b0});
        seq_a.push_back('{39, 1'b0, 4'b0000, 1'b1, 1'b0});
        seq_a.push_back('{40, 1'b1, 4'b1111, 1'b0, 1'b1});
        seq_a.push_back('{44, 1'b1, 4'b1111, 1'b0, 1'b1});
        seq_a.push_back('{45, 1'b0, 4'b1111, 1'b0, 1'b0});
        seq_a.push_back('{60, 1'b0, 4'b1111, 1'b0, 1'b0});
        seq_a.push_back('{61, 1'b0, 4'b1110, 1'b0, 1'b0});
        seq_a.push_back('{65, 1'b0, 4'b1100, 1'b0, 1'b0});
        seq_a.push_back('{72, 1'b0, 4'b1000, 1'b0, 1'b0});
        seq_a.push_back('{73, 1'b0, 4'b0000, 1'b1, 1'b0});

        // sw_req held from edge 0: ignored until RUN (entered at 31), honoured at edge 32.
        seq_b.push_back('{0,  1'b1, 4'b1111, 1'b0, 1'b0});
        seq_b.push_back('{18, 1'b1, 4'b1111, 1'b0, 1'b0});
        seq_b.push_back('{19, 1'b1, 4'b1110, 1'b0, 1'b0});
        seq_b.push_back('{30, 1'b1, 4'b1000, 1'b0, 1'b0});
        seq_b.push_back('{31, 1'b1, 4'b0000, 1'b1, 1'b0});
        seq_b.push_back('{32, 1'b1, 4'b1111, 1'b0, 1'b1});
        seq_b.push_back('{35, 1'b1, 4'b1111, 1'b0, 1'b1});
        seq_b.push_back('{36, 1'b0, 4'b1111, 1'b0, 1'b0});
        seq_b.push_back('{51, 1'b0, 4'b1111, 1'b0, 1'b0});
        seq_b.push_back('{52, 1'b0, 4'b1110, 1'b0, 1'b0});

        rst_n  = 1'b1;
        rst_n2 = 1'b1;
        sw_req = 1'b0;
        #1;
        rst_n  = 1'b0;
        rst_n2 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_dom_rst", 32'(dom_rst), 32'hf);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sw_ack", 32'(sw_ack), 32'd0);

        @(negedge clk);
        rst_n    = 1'b1;
        cur_edge = -1;
        run_vecs(seq_a);

        // Async assertion from RUN, no clock edge needed.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_from_run_dom_rst", 32'(dom_rst), 32'hf);
        check("async_from_run_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        sw_req   = 1'b1;
        rst_n    = 1'b1;
        cur_edge = -1;
        run_vecs(seq_b);

        // Mid-release short reset pulse at edge 25.
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        cur_edge = -1;
        while (cur_edge < 25) step();
        check("mid_pre_dom_rst", 32'(dom_rst), 32'hc);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_async_dom_rst", 32'(dom_rst), 32'hf);
        check("mid_async_done", 32'(done), 32'd0);
        #2;
        rst_n    = 1'b1;
        cur_edge = -1;
        while (cur_edge < 18) step();
        check("mid_restart_18", 32'(dom_rst), 32'hf);
        step();
        check("mid_restart_19", 32'(dom_rst), 32'he);

        // Minimum-parameter instance.
        @(negedge clk);
        rst_n2   = 1'b1;
        cur_edge = -1;
        while (cur_edge < 2) step();
        check("min_dom_rst_2", 32'(dom_rst2), 32'd1);
        check("min_done_2", 32'(done2), 32'd0);
        step();
        check("min_dom_rst_3", 32'(dom_rst2), 32'd0);
        check("min_done_3", 32'(done2), 32'd1);
        check("min_sw_ack_3", 32'(sw_ack2), 32'd0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
